// File: rtl/csr_intr_unit.sv
// Machine-mode CSR file and external-interrupt responder for the RV32 core.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_intr_unit #(
    parameter logic [31:0] MTVEC_BASE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        csr_we,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_src,
    input  logic [4:0]  csr_zimm,
    output logic [31:0] csr_rdata,
    input  logic        mret,
    input  logic        wfi,
    input  logic [31:0] resume_pc,
    input  logic        ext_irq,
    input  logic        retire,
    output logic        irq_wake,
    output logic        trap_take,
    output logic [31:0] trap_pc
);

    localparam logic [11:0] ADDR_MSTATUS    = 12'h300;
    localparam logic [11:0] ADDR_MIE        = 12'h304;
    localparam logic [11:0] ADDR_MTVEC      = 12'h305;
    localparam logic [11:0] ADDR_MEPC       = 12'h341;
    localparam logic [11:0] ADDR_MIP        = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE      = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH     = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET    = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH   = 12'hC82;

    typedef enum logic [1:0] {StRun, StSleep, StTrap} state_e;

    state_e      state_q, state_d;
    logic        mstatus_mie_q, mstatus_mpie_q;
    logic        mie_meie_q, mip_meip_q;
    logic [29:0] mepc_q;
    logic [63:0] mcycle_val, minstret_val;
    logic [31:0] src, wdata;
    logic        wr_op, take, trap_enter, run_ok, csr_commit, mret_commit;

    assign irq_wake = mip_meip_q & mie_meie_q;
    assign src      = csr_funct3[2] ? {27'b0, csr_zimm} : csr_src;

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0,
                                       mstatus_mie_q, 3'b0};
            ADDR_MIE:     csr_rdata = {20'b0, mie_meie_q, 11'b0};
            ADDR_MTVEC:   csr_rdata = {MTVEC_BASE[31:2], 2'b00};
            ADDR_MEPC:    csr_rdata = {mepc_q, 2'b00};
            ADDR_MIP:     csr_rdata = {20'b0, mip_meip_q, 11'b0};
            ADDR_MCYCLE, ADDR_CYCLE:       csr_rdata = mcycle_val[31:0];
            ADDR_MCYCLEH, ADDR_CYCLEH:     csr_rdata = mcycle_val[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:   csr_rdata = minstret_val[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: csr_rdata = minstret_val[63:32];
            default:      csr_rdata = '0;
        endcase
    end

    // Set/clear forms with a zero operand must not write (no side effects on RO/counters).
    always_comb begin
        wdata = src;
        wr_op = 1'b0;
        case (csr_funct3[1:0])
            2'b01: begin
                wdata = src;
                wr_op = 1'b1;
            end
            2'b10: begin
                wdata = csr_rdata | src;
                wr_op = |src;
            end
            2'b11: begin
                wdata = csr_rdata & ~src;
                wr_op = |src;
            end
            default: ;
        endcase
    end

    assign take        = (state_q == StRun) & irq_wake & mstatus_mie_q & ~stall & ~mret;
    assign run_ok      = (state_q == StRun) & ~stall & ~take;
    assign csr_commit  = csr_we & wr_op & run_ok;
    assign mret_commit = mret & run_ok;

    always_comb begin
        state_d    = state_q;
        trap_enter = 1'b0;
        trap_take  = 1'b0;
        case (state_q)
            StRun: begin
                if (take) begin
                    state_d    = StTrap;
                    trap_enter = 1'b1;
                end else if (wfi & ~irq_wake & ~stall) begin
                    state_d = StSleep;
                end
            end
            StSleep: begin
                if (irq_wake & ~stall) begin
                    if (mstatus_mie_q) begin
                        state_d    = StTrap;
                        trap_enter = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StTrap: begin
                trap_take = 1'b1;
                state_d   = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    assign trap_pc = trap_take ? {MTVEC_BASE[31:2], 2'b00} : {mepc_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRun;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mepc_q         <= '0;
        end else begin
            state_q    <= state_d;
            mip_meip_q <= ext_irq;
            if (trap_enter) begin
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
                mepc_q         <= resume_pc[31:2];
            end else begin
                if (mret_commit) begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                end else if (csr_commit && csr_addr == ADDR_MSTATUS) begin
                    mstatus_mie_q  <= wdata[3];
                    mstatus_mpie_q <= wdata[7];
                end
                if (csr_commit && csr_addr == ADDR_MIE) begin
                    mie_meie_q <= wdata[11];
                end
                if (csr_commit && csr_addr == ADDR_MEPC) begin
                    mepc_q <= wdata[31:2];
                end
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;

    // A committed write to one half holds the whole counter for that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_commit && csr_addr == ADDR_MCYCLE) begin
                mcycle_q <= {mcycle_q[63:32], wdata};
            end else if (csr_commit && csr_addr == ADDR_MCYCLEH) begin
                mcycle_q <= {wdata, mcycle_q[31:0]};
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end
            if (csr_commit && csr_addr == ADDR_MINSTRET) begin
                minstret_q <= {minstret_q[63:32], wdata};
            end else if (csr_commit && csr_addr == ADDR_MINSTRETH) begin
                minstret_q <= {wdata, minstret_q[31:0]};
            end else if (retire) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    assign mcycle_val   = mcycle_q;
    assign minstret_val = minstret_q;
`else
    assign mcycle_val   = '0;
    assign minstret_val = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{resume_pc[1:0], wdata[1:0], retire};

endmodule

// File: tb/tb_csr_intr_unit.sv
// Scoreboard bench for csr_intr_unit: directed scenarios then randomized traffic,
// checked against an architectural model of the CSR/interrupt rules.
module tb_csr_intr_unit;

    localparam logic [31:0] MTVEC = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall, csr_we, mret, wfi, ext_irq, retire;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_src, resume_pc;
    logic [4:0]  csr_zimm;
    logic [31:0] csr_rdata, trap_pc;
    logic        irq_wake, trap_take;

    csr_intr_unit #(.MTVEC_BASE(MTVEC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .csr_we(csr_we),
        .csr_funct3(csr_funct3), .csr_addr(csr_addr), .csr_src(csr_src),
        .csr_zimm(csr_zimm), .csr_rdata(csr_rdata), .mret(mret), .wfi(wfi),
        .resume_pc(resume_pc), .ext_irq(ext_irq), .retire(retire),
        .irq_wake(irq_wake), .trap_take(trap_take), .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        wake;
        logic        take;
        logic [31:0] pc;
        logic [11:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   trap_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   drv_cyc = 0;

    // Architectural model: full 32-bit register images plus sleep/trap flags.
    logic [31:0] m_mstatus, m_mie, m_mepc, m_mip;
    logic [63:0] m_mcycle, m_minstret;
    bit          m_sleep, m_trap;
    logic        g_irq;
    logic [31:0] g_rpc;

    logic [11:0] addr_tbl [12] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344, 12'h7C0,
                                   12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC82};
    logic [2:0]  f3_tbl [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return MTVEC;
            12'h341: return m_mepc;
            12'h344: return m_mip;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: return m_mcycle[31:0];
            12'hB80, 12'hC80: return m_mcycle[63:32];
            12'hB02, 12'hC02: return m_minstret[31:0];
            12'hB82, 12'hC82: return m_minstret[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 32'h0000_1800;
        m_mie = 0; m_mepc = 0; m_mip = 0;
        m_mcycle = 0; m_minstret = 0;
        m_sleep = 0; m_trap = 0;
    endtask

    task automatic enter_trap(input logic [31:0] rpc);
        m_mepc    = rpc & ~32'h3;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        m_trap    = 1;
        trap_q.push_back(drv_cyc);
    endtask

    task automatic cycle(input logic s, input logic we, input logic [2:0] f3,
                         input logic [11:0] a, input logic [31:0] sv, input logic [4:0] z,
                         input logic mr, input logic wf, input logic [31:0] rpc,
                         input logic irq, input logic ret);
        exp_t        e;
        logic        wake, do_wr;
        logic [31:0] old, srcv, wd;
`ifdef CSR_COUNTERS_EN
        bit          wr_cyc, wr_ins;
        wr_cyc = 0;
        wr_ins = 0;
`endif
        stall = s; csr_we = we; csr_funct3 = f3; csr_addr = a; csr_src = sv;
        csr_zimm = z; mret = mr; wfi = wf; resume_pc = rpc; ext_irq = irq; retire = ret;
        wake    = (m_mip & m_mie) != 0;
        e.rdata = m_read(a);
        e.wake  = wake;
        e.take  = m_trap;
        e.pc    = m_trap ? MTVEC : m_mepc;
        e.addr  = a;
        exp_q.push_back(e);
        @(posedge clk);
        drv_cyc++;
        old  = m_read(a);
        srcv = f3[2] ? {27'b0, z} : sv;
        case (f3[1:0])
            2'b01:   wd = srcv;
            2'b10:   wd = old | srcv;
            2'b11:   wd = old & ~srcv;
            default: wd = old;
        endcase
        do_wr = we && (f3[1:0] == 2'b01 || (f3[1:0] != 2'b00 && srcv != 0));
        if (m_trap) begin
            m_trap = 0;
        end else if (m_sleep) begin
            if (wake && !s) begin
                m_sleep = 0;
                if (m_mstatus[3]) enter_trap(rpc);
            end
        end else if (!s) begin
            if (wake && m_mstatus[3] && !mr) begin
                enter_trap(rpc);
            end else begin
                if (mr) begin
                    m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
                end else if (do_wr) begin
                    case (a)
                        12'h300: m_mstatus = 32'h1800 | (wd & 32'h88);
                        12'h304: m_mie = wd & 32'h800;
                        12'h341: m_mepc = wd & ~32'h3;
`ifdef CSR_COUNTERS_EN
                        12'hB00: begin m_mcycle[31:0] = wd; wr_cyc = 1; end
                        12'hB80: begin m_mcycle[63:32] = wd; wr_cyc = 1; end
                        12'hB02: begin m_minstret[31:0] = wd; wr_ins = 1; end
                        12'hB82: begin m_minstret[63:32] = wd; wr_ins = 1; end
`endif
                        default: ;
                    endcase
                end
                if (wf && !wake) m_sleep = 1;
            end
        end
`ifdef CSR_COUNTERS_EN
        if (!wr_cyc) m_mcycle = m_mcycle + 1;
        if (!wr_ins && ret) m_minstret = m_minstret + 1;
`endif
        m_mip = irq ? 32'h800 : 32'h0;
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        cycle(0, 0, 3'b000, a, 0, 0, 0, 0, g_rpc, g_irq, 0);
    endtask

    task automatic wr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] v);
        cycle(0, 1, f3, a, v, v[4:0], 0, 0, g_rpc, g_irq, 0);
    endtask

    task automatic do_reset();
        stall = 0; csr_we = 0; csr_funct3 = 0; csr_addr = 0; csr_src = 0; csr_zimm = 0;
        mret = 0; wfi = 0; resume_pc = 0; ext_irq = 0; retire = 0; g_irq = 0;
        rst_n = 1'b0;
        exp_q.delete();
        trap_q.delete();
        model_reset();
        #1;
        check("rst_trap_take", {31'b0, trap_take}, 32'h0);
        check("rst_irq_wake", {31'b0, irq_wake}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("rdata_%h", e.addr), csr_rdata, e.rdata);
            check("irq_wake", {31'b0, irq_wake}, {31'b0, e.wake});
            check("trap_take", {31'b0, trap_take}, {31'b0, e.take});
            check("trap_pc", trap_pc, e.pc);
        end
        if (rst_n && trap_take === 1'b1) begin
            if (trap_q.size() == 0) check("unexpected_trap", {31'b0, trap_take}, 32'h0);
            else check("trap_cycle", drv_cyc, trap_q.pop_front());
        end
    end

    initial begin
        g_rpc = 32'h200;
        #2;
        do_reset();
        rd(12'h300); rd(12'h304); rd(12'h341); rd(12'h344); rd(12'h305); rd(12'h7C0);

        // Enable interrupts, raise the line, trap, return, re-trap.
        wr(3'b010, 12'h300, 32'h8);
        wr(3'b001, 12'h304, 32'h800);
        g_irq = 1;
        rd(12'h300); rd(12'h300); rd(12'h341); rd(12'h300);
        cycle(0, 0, 3'b000, 12'h300, 0, 0, 1, 0, g_rpc, g_irq, 0);
        rd(12'h300); rd(12'h341); rd(12'h300);

        // Sleep with MIE=0: wake returns to run without a trap.
        wr(3'b011, 12'h300, 32'h88);
        g_irq = 0;
        rd(12'h344); rd(12'h344);
        cycle(0, 0, 3'b000, 12'h300, 0, 0, 0, 1, g_rpc, g_irq, 0);
        rd(12'h300); rd(12'h300);
        g_irq = 1;
        rd(12'h344); rd(12'h344); rd(12'h300);

        wr(3'b011, 12'h341, 32'h0);
        wr(3'b001, 12'h344, 32'hFFFF_FFFF);
        rd(12'h344); rd(12'h7C0); rd(12'h341);
        cycle(1, 1, 3'b001, 12'h304, 32'h0, 0, 0, 0, g_rpc, g_irq, 0);
        rd(12'h304);
        g_irq = 0;
        rd(12'h300);

`ifdef CSR_COUNTERS_EN
        wr(3'b001, 12'hB00, 32'hFFFF_FFFF);
        wr(3'b001, 12'hB80, 32'hFFFF_FFFF);
        rd(12'hB80); rd(12'hB80); rd(12'hC00);
        cycle(0, 1, 3'b001, 12'hB02, 32'h1234, 0, 0, 0, g_rpc, g_irq, 1);
        rd(12'hB02); rd(12'hC82);
`else
        wr(3'b001, 12'hB00, 32'h1234);
        rd(12'hB00); rd(12'hC00); rd(12'hB82);
`endif

        // Reset while sleeping, then while a trap pulse is pending.
        cycle(0, 0, 3'b000, 12'h300, 0, 0, 0, 1, g_rpc, g_irq, 0);
        rd(12'h300);
        do_reset();
        rd(12'h300);
        wr(3'b010, 12'h300, 32'h8);
        wr(3'b001, 12'h304, 32'h800);
        g_irq = 1;
        rd(12'h300); rd(12'h300);
        do_reset();
        rd(12'h300); rd(12'h341); rd(12'h304);

        for (int i = 0; i < 800; i++) begin
            logic        s, we, mr, wf;
            logic [31:0] v;
            int          r;
            s  = ($urandom_range(0, 7) == 0);
            r  = $urandom_range(0, 9);
            we = (r < 5);
            mr = (r == 5);
            wf = (r == 6);
            if ($urandom_range(0, 5) == 0) g_irq = ~g_irq;
            v  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            cycle(s, we, f3_tbl[$urandom_range(0, 5)], addr_tbl[$urandom_range(0, 11)], v,
                  v[4:0], mr, wf, $urandom, g_irq, 1'($urandom_range(0, 1)));
        end

        rd(12'h300);
        @(negedge clk);
        #1;
        check("trap_q_drain", trap_q.size(), 32'h0);
        check("exp_q_drain", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
